mc_sequencer: RTL

- Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle controller's one-instruction-per-clock timing.
- One shared instruction/data memory port with a req/ready handshake, so memory latency is variable.
- Drives PC/IR/regfile/memory strobes to the existing datapath units (Reg_PC, RegFile, ALU, JB_Unit, LD_Filter).
- Adds illegal-opcode trap, bus-timeout error and optional performance counters.

---
 rtl/mc_sequencer_if.sv | 22 ++
 rtl/mc_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer_if.sv
// Shared instruction/data memory port: the sequencer holds mem_req until the
// memory answers with mem_ready.
interface mc_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer with one shared memory port, illegal-opcode trap and
// bus timeout. Define PERF_CNT_EN to build the cycle / retired-instruction counters.
module mc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             b,
    mc_sequencer_if.master   mem,
    output logic             ir_en,
    output logic             pc_en,
    output logic             next_pc_sel,
    output logic             wb_en,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;

    logic [2:0]      state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            illegal_q, illegal_d;
    logic            bus_err_q, bus_err_d;

    logic is_legal, is_load, is_store, is_branch, is_jump;
    logic to_hit;
    logic req, we, asel;

    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: is_legal = 1'b1;
            default:                          is_legal = 1'b0;
        endcase
    end

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

    // Last allowed wait cycle; a ready in this cycle still completes the access.
    assign to_hit = (to_q == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        to_d        = to_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        req         = 1'b0;
        we          = 1'b0;
        asel        = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        next_pc_sel = 1'b0;
        wb_en       = 1'b0;

        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (mem.mem_ready) begin
                    ir_en   = 1'b1;
                    state_d = DECODE;
                end else if (to_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            DECODE: begin
                if (is_legal) begin
                    state_d = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXEC: begin
                if (is_branch) begin
                    pc_en       = 1'b1;
                    next_pc_sel = b;
                    state_d     = FETCH;
                    to_d        = '0;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                    to_d    = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                req  = 1'b1;
                asel = 1'b1;
                we   = is_store;
                if (mem.mem_ready) begin
                    if (is_store) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                        to_d    = '0;
                    end else begin
                        state_d = WB;
                    end
                end else if (to_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = TRAP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            WB: begin
                wb_en       = 1'b1;
                pc_en       = 1'b1;
                next_pc_sel = is_jump;
                state_d     = FETCH;
                to_d        = '0;
            end
            TRAP: begin
                state_d = TRAP;
            end
            // Unused encodings park in TRAP rather than issuing strobes.
            default: begin
                state_d = TRAP;
            end
        endcase

        if (rst) begin
            req         = 1'b0;
            we          = 1'b0;
            asel        = 1'b0;
            ir_en       = 1'b0;
            pc_en       = 1'b0;
            next_pc_sel = 1'b0;
            wb_en       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            to_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_q      <= to_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem.mem_req      = req;
    assign mem.mem_we       = we;
    assign mem.mem_addr_sel = asel;
    assign state            = state_q;
    assign illegal          = illegal_q;
    assign bus_err          = bus_err_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != TRAP) cyc_q <= cyc_q + 1'b1;
            if (pc_en)           ret_q <= ret_q + 1'b1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
